// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the round-robin FIFO drain scheduler.
package fifo_sched_pkg;

    typedef enum logic [1:0] {IDLE, POP, CAPT, HOLD} sched_state_t;

    // Index width for n sources; kept at least 1 bit so single-source builds stay legal.
    function automatic int src_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rr_scheduler_arb.sv
// Combinational rotating-priority arbiter: the first requester at or above ptr wins,
// wrapping modulo N.
module rr_arbiter
    import fifo_sched_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = src_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_any
);

    // Scan from the farthest offset down so the nearest requester is assigned last and wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_idx = W'(idx);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Drains N_SRC count/pop FIFOs into one valid/ready stream, serving up to BURST words
// per grant before rotating priority.
module fifo_rr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter  int N_SRC  = 4,
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 4,
    parameter  int BURST  = 4,
    localparam int SW     = src_w(N_SRC),
    localparam int BW     = $clog2(BURST + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_SRC*CNT_W-1:0]    src_count,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    output logic [N_SRC-1:0]          src_pop,
    output logic [DATA_W-1:0]         out_data,
    output logic [SW-1:0]             out_src,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    sched_state_t        state;
    logic [SW-1:0]       grant;
    logic [SW-1:0]       rr_ptr;
    logic [BW-1:0]       burst_cnt;
    logic [N_SRC-1:0]    pop_r;
    logic [N_SRC-1:0]    elig;
    logic [SW-1:0]       win_idx;
    logic                win_any;
    logic [DATA_W-1:0]   sel_data;
    logic                more;
    logic [SW-1:0]       next_ptr;

    function automatic logic [N_SRC-1:0] onehot(input logic [SW-1:0] i);
        logic [N_SRC-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_SRC; i++) begin
            elig[i] = (src_count[i*CNT_W +: CNT_W] != '0);
        end
    end

    rr_arbiter #(.N(N_SRC)) u_arb (
        .req     (elig),
        .ptr     (rr_ptr),
        .gnt_idx (win_idx),
        .gnt_any (win_any)
    );

    assign sel_data = src_data[int'(grant)*DATA_W +: DATA_W];
    assign more     = (burst_cnt < BW'(BURST)) && elig[grant];
    assign next_ptr = (grant == SW'(N_SRC - 1)) ? '0 : grant + 1'b1;

    // The pop strobe is registered on entry to POP; reset masks it so no pop escapes that cycle.
    assign src_pop = reset ? '0 : pop_r;
    assign busy    = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            pop_r     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            pop_r <= '0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        grant     <= win_idx;
                        burst_cnt <= '0;
                        pop_r     <= onehot(win_idx);
                        state     <= POP;
                    end
                end
                POP: begin
                    state <= CAPT;
                end
                CAPT: begin
                    out_data  <= sel_data;
                    out_src   <= grant;
                    out_valid <= 1'b1;
                    burst_cnt <= burst_cnt + 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (more) begin
                            pop_r <= onehot(grant);
                            state <= POP;
                        end else begin
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
